// File: rtl/mips16_commit_tracker_pkg.sv
// Shared types for the MIPS16 commit tracker: pipeline shadow slots and commit records.
`ifndef PC_WIDTH
`define PC_WIDTH 8
`endif

package mips16_commit_tracker_pkg;

    localparam int PC_W    = `PC_WIDTH;
    localparam int INSTR_W = 16;
    localparam int DATA_W  = 16;
    localparam int REG_W   = 3;

    typedef struct packed {
        logic               valid;
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } shadow_slot_t;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
        logic               wen;
        logic [REG_W-1:0]   dest;
        logic [DATA_W-1:0]  data;
    } commit_rec_t;

    localparam shadow_slot_t SLOT_EMPTY = '0;

endpackage

// File: rtl/mips16_commit_tracker_if.sv
// Commit-record stream from the tracker (master) to the scoreboard (slave).
`ifndef PC_WIDTH
`define PC_WIDTH 8
`endif

interface mips16_commit_tracker_if #(
    parameter int PC_WIDTH   = `PC_WIDTH,
    parameter int FIFO_DEPTH = 4
);
    logic                              commit_valid;
    logic                              commit_ready;
    logic [PC_WIDTH-1:0]               commit_pc;
    logic [15:0]                       commit_instr;
    logic                              commit_wen;
    logic [2:0]                        commit_dest;
    logic [15:0]                       commit_data;
    logic [$clog2(FIFO_DEPTH+1)-1:0]   commit_count;
    logic                              overflow;

    modport master (
        output commit_valid, commit_pc, commit_instr, commit_wen,
               commit_dest, commit_data, commit_count, overflow,
        input  commit_ready
    );

    modport slave (
        input  commit_valid, commit_pc, commit_instr, commit_wen,
               commit_dest, commit_data, commit_count, overflow,
        output commit_ready
    );
endinterface

// File: rtl/mips16_commit_fifo.sv
// First-word fall-through FIFO; a push when full only lands if a pop frees the slot that cycle.
module mips16_commit_fifo #(
    parameter type T     = logic,
    parameter int  DEPTH = 4,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  T              wdata,
    input  logic          pop,
    output T              rdata,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);
    T              mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        count_d = count_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) mem_q[wr_ptr_q] <= wdata;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;
endmodule

// File: rtl/mips16_commit_tracker.sv
// Shadows IF->ID->EX->MEM->WB and queues one commit record per retired (valid) WB slot.
`ifndef PC_WIDTH
`define PC_WIDTH 8
`endif

module mips16_commit_tracker
    import mips16_commit_tracker_pkg::*;
#(
    parameter int PC_WIDTH   = `PC_WIDTH,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [PC_WIDTH-1:0]   pc,
    input  logic [15:0]           instruction,
    input  logic                  pipeline_stall_n,
    input  logic                  branch_taken,
    input  logic                  reg_write_en,
    input  logic [2:0]            reg_write_dest,
    input  logic [15:0]           reg_write_data,
    mips16_commit_tracker_if.master cif
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    shadow_slot_t  id_q, id_d, ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
    commit_rec_t   rec, head;
    logic          push, pop, full, empty;
    logic          overflow_q, overflow_d;
    logic [CW-1:0] count;

    // A stall freezes ID and injects a bubble into EX; MEM/WB always advance.
    always_comb begin
        id_d  = id_q;
        ex_d  = SLOT_EMPTY;
        if (pipeline_stall_n) begin
            id_d = '{valid: ~branch_taken, pc: PC_W'(pc), instr: instruction};
            ex_d = id_q;
        end
        mem_d = ex_q;
        wb_d  = mem_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            id_q       <= SLOT_EMPTY;
            ex_q       <= SLOT_EMPTY;
            mem_q      <= SLOT_EMPTY;
            wb_q       <= SLOT_EMPTY;
            overflow_q <= 1'b0;
        end else begin
            id_q       <= id_d;
            ex_q       <= ex_d;
            mem_q      <= mem_d;
            wb_q       <= wb_d;
            overflow_q <= overflow_d;
        end
    end

    assign push = wb_q.valid;
    assign pop  = !empty && cif.commit_ready;
    assign rec  = '{pc: wb_q.pc, instr: wb_q.instr, wen: reg_write_en,
                    dest: reg_write_dest, data: reg_write_data};
    assign overflow_d = overflow_q | (push && full && !pop);

    mips16_commit_fifo #(
        .T     (commit_rec_t),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (rec),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    assign cif.commit_valid = !empty;
    assign cif.commit_pc    = PC_WIDTH'(head.pc);
    assign cif.commit_instr = head.instr;
    assign cif.commit_wen   = head.wen;
    assign cif.commit_dest  = head.dest;
    assign cif.commit_data  = head.data;
    assign cif.commit_count = count;
    assign cif.overflow     = overflow_q;
endmodule

// File: tb/tb_mips16_commit_tracker.sv
// Scoreboard bench: expected commit records are queued at capture and checked when the DUT pops them.
module tb_mips16_commit_tracker;
    localparam int PCW   = 8;
    localparam int DEPTH = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [PCW-1:0]  pc;
    logic [15:0]     instruction;
    logic            pipeline_stall_n;
    logic            branch_taken;
    logic            reg_write_en;
    logic [2:0]      reg_write_dest;
    logic [15:0]     reg_write_data;

    mips16_commit_tracker_if #(.PC_WIDTH(PCW), .FIFO_DEPTH(DEPTH)) cif ();

    mips16_commit_tracker #(.PC_WIDTH(PCW), .FIFO_DEPTH(DEPTH)) dut (
        .clk              (clk),
        .rst              (rst),
        .pc               (pc),
        .instruction      (instruction),
        .pipeline_stall_n (pipeline_stall_n),
        .branch_taken     (branch_taken),
        .reg_write_en     (reg_write_en),
        .reg_write_dest   (reg_write_dest),
        .reg_write_data   (reg_write_data),
        .cif              (cif)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [PCW-1:0] pc;
        logic [15:0]    instr;
        logic           wen;
        logic [2:0]     dest;
        logic [15:0]    data;
        int             at;   // cycle the record should reach the head; 0 = unchecked
    } exp_t;

    exp_t exp_q[$];
    bit   held = 0;
    int   total = 0;
    int   bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h (cyc %0d)", tag, got, want, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && cif.commit_valid && cif.commit_ready) begin
            if (exp_q.size() == 0) begin
                chk("extra_rec_pc", {24'h0, cif.commit_pc}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("pc",    cif.commit_pc,    e.pc);
                chk("instr", cif.commit_instr, e.instr);
                chk("wen",   cif.commit_wen,   e.wen);
                chk("dest",  cif.commit_dest,  e.dest);
                chk("data",  cif.commit_data,  e.data);
                if (e.at != 0) chk("latency", cyc, e.at);
            end
        end
    end

    task automatic set_wb(input logic we, input logic [2:0] d, input logic [15:0] dat);
        reg_write_en   = we;
        reg_write_dest = d;
        reg_write_data = dat;
    endtask

    // One cycle of fetch-side stimulus; ew/ed/edat are the WB values this instruction will retire with.
    task automatic fetch(input logic [PCW-1:0] p, input logic [15:0] ins, input bit stl_n,
                         input bit br, input bit sb, input bit lat,
                         input logic ew, input logic [2:0] ed, input logic [15:0] edat);
        exp_t e;
        pc = p; instruction = ins; pipeline_stall_n = stl_n; branch_taken = br;
        @(posedge clk); #1;
        set_wb(1'b0, 3'd0, 16'h0);
        if (stl_n && !br) begin
            if (sb) begin
                e = '{pc: p, instr: ins, wen: ew, dest: ed, data: edat, at: lat ? cyc + 4 : 0};
                exp_q.push_back(e);
            end
            held = sb;
        end else if (stl_n) begin
            held = 0;
        end else if (held && exp_q.size() > 0 && exp_q[exp_q.size()-1].at != 0) begin
            exp_q[exp_q.size()-1].at = exp_q[exp_q.size()-1].at + 1;
        end
    endtask

    task automatic go(input logic [PCW-1:0] p, input logic [15:0] ins);
        fetch(p, ins, 1, 0, 1, 1, 1'b0, 3'd0, 16'h0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) fetch(8'h0, 16'h0, 1, 1, 0, 0, 1'b0, 3'd0, 16'h0);
    endtask

    initial begin
        rst = 1; pc = '0; instruction = '0; pipeline_stall_n = 1; branch_taken = 1;
        set_wb(1'b0, 3'd0, 16'h0);
        cif.commit_ready = 1;
        idle(2);
        chk("rst_valid", cif.commit_valid, 0);
        chk("rst_count", cif.commit_count, 0);
        chk("rst_ovf",   cif.overflow,     0);
        chk("rst_pc",    cif.commit_pc,    0);
        chk("rst_data",  cif.commit_data,  0);
        rst = 0;
        idle(2);

        // Straight line, pc 0 is a NOP; pc1 retires with wen/5/BEEF, pc3 with wen/2/1234.
        go(8'h00, 16'h0000);
        fetch(8'h01, 16'hA101, 1, 0, 1, 1, 1'b1, 3'd5, 16'hBEEF);
        go(8'h02, 16'hA202);
        fetch(8'h03, 16'hA303, 1, 0, 1, 1, 1'b1, 3'd2, 16'h1234);
        go(8'h04, 16'hA404);
        set_wb(1'b1, 3'd5, 16'hBEEF);
        idle(2);
        set_wb(1'b1, 3'd2, 16'h1234);
        idle(8);

        // Stall while pc 0x12 sits in ID.
        go(8'h10, 16'hB010);
        go(8'h11, 16'hB011);
        go(8'h12, 16'hB012);
        fetch(8'h13, 16'hB013, 0, 0, 1, 1, 1'b0, 3'd0, 16'h0);
        go(8'h13, 16'hB013);
        go(8'h14, 16'hB014);
        idle(8);

        // Branch squash of pc 0x23; target 0x40.
        go(8'h20, 16'hC020);
        go(8'h21, 16'hC021);
        go(8'h22, 16'hC022);
        fetch(8'h23, 16'hC023, 1, 1, 1, 1, 1'b0, 3'd0, 16'h0);
        go(8'h40, 16'hC040);
        go(8'h41, 16'hC041);
        idle(8);
        chk("ovf_clear", cif.overflow, 0);

        // Overflow: six retirements into a four-deep queue with no consumer.
        cif.commit_ready = 0;
        for (int i = 0; i < 6; i++)
            fetch(PCW'(8'h50 + i), 16'hD000 + 16'(i), 1, 0, (i < DEPTH), 0, 1'b0, 3'd0, 16'h0);
        idle(8);
        chk("ovf_count", cif.commit_count, DEPTH);
        chk("ovf_flag",  cif.overflow,     1);
        chk("ovf_valid", cif.commit_valid, 1);
        cif.commit_ready = 1;
        idle(8);
        chk("drain_count", cif.commit_count, 0);
        chk("ovf_sticky",  cif.overflow,     1);

        // Reset with three valid slots and two queued records.
        cif.commit_ready = 0;
        for (int i = 0; i < 5; i++)
            fetch(PCW'(8'h60 + i), 16'hE000 + 16'(i), 1, 0, 0, 0, 1'b0, 3'd0, 16'h0);
        idle(1);
        chk("pre_rst_count", cif.commit_count, 2);
        rst = 1;
        idle(1);
        rst = 0;
        exp_q.delete();
        held = 0;
        chk("mrst_valid", cif.commit_valid, 0);
        chk("mrst_count", cif.commit_count, 0);
        chk("mrst_ovf",   cif.overflow,     0);
        chk("mrst_pc",    cif.commit_pc,    0);
        cif.commit_ready = 1;
        idle(10);
        chk("post_rst_valid", cif.commit_valid, 0);
        go(8'h70, 16'hF070);
        idle(8);

        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
        chk("drain_left", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mips16_commit_tracker.md
# mips16_commit_tracker

Synthesizable shadow of the MIPS16 five-stage pipeline for the verification bench. It samples the fetch-side signals (`pc`, `instruction`) and the hazard and branch controls, and tracks each fetched instruction through ID/EX/MEM/WB. At writeback it pairs the instruction with the register-file write signals and emits one commit record per retired instruction through a valid/ready FIFO, which the scoreboard drains.

## Interface
Parameters:
- `PC_WIDTH`, default `` `PC_WIDTH `` (8): width of the program counter.
- `FIFO_DEPTH`, default 4: commit-queue entries. Must be a power of two, ≥ 2.

Ports:
- `clk`  in  1  pipeline clock.
- `rst`  in  1  reset. Synchronous, active-high.
- `pc`  in  PC_WIDTH  PC of the instruction in IF.
- `instruction`  in  16  instruction word in IF.
- `pipeline_stall_n`  in  1  0 = hazard stall; IF and ID hold, a bubble enters EX.
- `branch_taken`  in  1  branch resolved taken in ID; squashes the instruction in IF.
- `reg_write_en`  in  1  writeback enable of the instruction in WB.
- `reg_write_dest`  in  3  writeback register.
- `reg_write_data`  in  16  writeback data.
- `commit_valid`  out  1  head record available.
- `commit_ready`  in  1  consumer accepts head.
- `commit_pc`  out  PC_WIDTH  head record PC.
- `commit_instr`  out  16  head record instruction.
- `commit_wen`  out  1  head record write enable.
- `commit_dest`  out  3  head record destination.
- `commit_data`  out  16  head record write data.
- `commit_count`  out  $clog2(FIFO_DEPTH+1)  FIFO occupancy.
- `overflow`  out  1  sticky flag; a record was dropped.

## Operation
- There are four shadow slots: `id`, `ex`, `mem`, `wb`. Each slot holds `{valid, pc, instr}`.
- Every rising edge when not in reset:
  - If `pipeline_stall_n`=1: `id` ← `{~branch_taken, pc, instruction}`, and `ex` ← `id`.
  - If `pipeline_stall_n`=0: `id` holds, and `ex` ← bubble (valid=0). `branch_taken` is ignored while stalled.
  - `mem` ← `ex` and `wb` ← `mem`, unconditionally.
- Retire rule: if `wb.valid`=1 in a cycle, push the record `{wb.pc, wb.instr, reg_write_en, reg_write_dest, reg_write_data}` at the end of that cycle.
  - Bubbles and squashed slots never commit.
  - A NOP (`instruction`=0) does commit.
- FIFO behaviour:
  - First-word fall-through: the commit outputs show the head whenever `commit_valid`=1.
  - Pop occurs when `commit_valid && commit_ready`.
  - Push when full and no pop in the same cycle: the record is dropped, `overflow` ← 1, and the FIFO contents are unchanged.
  - Push and pop in the same cycle when full: both happen and nothing is dropped.
  - Push and pop in the same cycle when empty: the push is stored, and `commit_valid` rises on the next cycle (no bypass).
  - Read and write pointers wrap modulo FIFO_DEPTH. Occupancy = `commit_count`.
- `overflow` stays set until `rst`.
- Reset:
  - All slots become invalid, the FIFO empties, and `overflow`=0.
  - `commit_valid`=0, `commit_count`=0, and all `commit_*` data outputs are 0.
  - Reset asserted mid-operation discards every in-flight instruction and every queued record.

## Timing
- Capture: an instruction sampled at edge E (stall_n=1, branch_taken=0) occupies `id` after E, `ex` after E+1, `mem` after E+2, and `wb` after E+3.
- It is pushed at E+4, and `commit_valid` is high after E+4.
- Each stall cycle that holds an instruction in `id` adds exactly one cycle to its latency.
- Throughput: at most one commit per cycle.
- `commit_ready` is sampled only at the clock edge. Outputs are registered; there is no combinational path from inputs to `commit_*`.

## Structure
- Add to `MIPS_pkg`:
  - `shadow_slot_t` (packed: valid, pc, instr).
  - `commit_rec_t` (packed: pc, instr, wen, dest, data).
- Sub-module `mips16_commit_fifo`: parameterized by type and depth, with push/pop, full/empty, and count.
- The tracker top level holds the slot registers and the retire logic.

## Test plan
- Straight line: PCs 0–4 fetched with no stall or branch, consumer always ready → five records with pc 0,1,2,3,4 in order. The first `commit_valid` is 4 edges after the first capture.
- Stall: one cycle of `pipeline_stall_n`=0 while pc 2 is in `id` → no duplicate record; pc 2 commits exactly one cycle later than in the straight-line case.
- Branch squash: `branch_taken`=1 on the edge capturing pc 3 → no record for pc 3; the next record is the branch target PC.
- Writeback pairing: `reg_write_en`=1, dest 5, data 0xBEEF while pc 1 is in WB → that record has wen=1, dest=5, data=0xBEEF.
- Overflow: `commit_ready`=0 with FIFO_DEPTH=4 for 6 retirements → `commit_count`=4 and `overflow`=1. The first four records drain in order, and `overflow` stays 1.
- Reset mid-flight: `rst` asserted for one edge with 3 slots valid and 2 records queued → `commit_valid`=0, `commit_count`=0, `overflow`=0, and no stale records appear afterwards.
